mbe_mul_sched: RTL and testbench
================================

Name: mbe_mul_sched

Overview:
- Shares one pipelined 24x24 radix-8 MBE multiplier (booth encoder + dadda_tree + final adder) between N_REQ requesters.
- Round-robin arbitration with one outstanding operation per requester.
- Tags each issued operation and steers the 48-bit product back to a per-requester response register with valid/ready handshake.
- Sits between the client engines and the multiplier datapath; the multiplier itself is external.

Parameters:
- N_REQ, 4, number of requesters (1..8).
- MUL_LAT, 2, fixed multiplier latency in cycles from mul_valid to valid mul_p (>=1).
- OP_W, 24, operand width.
- P_W, 48, product width (2*OP_W).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant; one-hot or zero.
- req_a  in  N_REQ*OP_W  multiplicand, slice i = requester i.
- req_b  in  N_REQ*OP_W  multiplier, slice i = requester i.
- mul_valid  out  1  operands on mul_a/mul_b valid this cycle.
- mul_a  out  OP_W  operand A to multiplier.
- mul_b  out  OP_W  operand B to multiplier.
- mul_p  in  P_W  product from multiplier, valid MUL_LAT cycles after the matching mul_valid.
- rsp_valid  out  N_REQ  per-requester response valid.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_p  out  N_REQ*P_W  per-requester product register.
- inflight_cnt  out  4  number of operations issued but not yet returned to a response register.

Behaviour:
- Reset (rst_n=0 at clk edge): mul_valid=0, mul_a=mul_b=0, rsp_valid=0, rsp_p=0, inflight_cnt=0. Round-robin pointer=0. All busy flags and tag-pipe valids cleared. Reset mid-operation discards in-flight products; mul_p arriving after reset is ignored.
- busy[i] is registered. It is set on grant to i and cleared when rsp_valid[i]&rsp_ready[i] handshakes.
- eligible[i] = req_valid[i] & ~busy[i].
- Arbitration is combinational from registered state. Search starts at pointer ptr, ascending with wrap. The first eligible i gets req_ready[i]=1; at most one grant per cycle.
- On a grant to i: ptr <= (i+1) mod N_REQ. With no grant, ptr holds.
- Requests are accepted on req_valid[i]&req_ready[i].
- Accept in cycle t:
  - mul_valid=1 with registered req_a/req_b slice i in cycle t+1.
  - Tag {valid,i} enters an MUL_LAT-deep shift register aligned with the multiplier pipe.
  - mul_p is captured into rsp_p[i] at the end of cycle t+1+MUL_LAT.
  - rsp_valid[i]=1 from cycle t+2+MUL_LAT.
  - Fixed latency, accept to rsp_valid = MUL_LAT+2.
- With no grant, mul_valid=0 and mul_a/mul_b hold their previous values.
- Peak throughput is one issue per cycle across requesters. A single requester can issue at most once per MUL_LAT+3 cycles, because rsp handshake frees busy only for the next cycle. A same-cycle handshake and re-grant is not allowed.
- rsp_p[i] and rsp_valid[i] hold until handshake; rsp_ready with rsp_valid=0 has no effect.
- Response-register capacity is guaranteed by busy, so the tag pipe never stalls. The multiplier has no backpressure.
- req_a/req_b are ignored when not granted. Operand/product interpretation (two's complement) belongs to the multiplier; the block only routes bits.
- inflight_cnt updates:
  - increments on accept;
  - decrements on the tag-pipe output capture;
  - holds when both happen in the same cycle.
  - Max value is min(N_REQ, MUL_LAT+1).
- N_REQ=1: ptr is constant 0; behaviour is otherwise identical.

Test Plan:
- Single request, rsp_ready=1: req0 a=3, b=5 accepted at t → mul_valid at t+1 with mul_a=3, mul_b=5; rsp_valid[0] at t+4 (MUL_LAT=2) with rsp_p=15; inflight_cnt 1 then 0.
- All 4 requesters valid from reset, rsp_ready=1 → grants in cycles 0,1,2,3 to req 0,1,2,3; inflight_cnt peaks at 3; each rsp arrives 4 cycles after its grant.
- Hold rsp_ready[1]=0 with req_valid[1]=1 → after first grant, req1 is never re-granted while rsp_valid[1]=1. Others keep rotating. Raise rsp_ready[1] for one cycle → req1 granted in the following cycle, not the same cycle.
- Fairness: ptr=2, req 0 and 3 valid → req3 granted first, then req0.
- Signed extreme: a=b=0x800000 → rsp_p=0x400000000000 routed to the correct requester slice only.
- Reset asserted one cycle after an accept → all rsp_valid stay 0, inflight_cnt=0. A late mul_p is ignored, and the next request completes normally.

Source files
------------

// File: rtl/mbe_mul_sched.sv
// Round-robin scheduler sharing one pipelined MBE multiplier among requesters.
// Tags follow the multiplier pipe and steer each product to its response register.
module mbe_mul_sched #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 2,
    parameter int OP_W    = 24,
    parameter int P_W     = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*OP_W-1:0] req_a,
    input  logic [N_REQ*OP_W-1:0] req_b,
    output logic                  mul_valid,
    output logic [OP_W-1:0]       mul_a,
    output logic [OP_W-1:0]       mul_b,
    input  logic [P_W-1:0]        mul_p,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [N_REQ*P_W-1:0]  rsp_p,
    output logic [3:0]            inflight_cnt
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]             busy_q, busy_d;
    logic [ID_W-1:0]              ptr_q, ptr_d;
    logic                         mul_valid_q, mul_valid_d;
    logic [OP_W-1:0]              mul_a_q, mul_a_d;
    logic [OP_W-1:0]              mul_b_q, mul_b_d;
    logic [ID_W-1:0]              iss_id_q, iss_id_d;
    logic [MUL_LAT-1:0]           tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic [N_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0][P_W-1:0]    rsp_p_q, rsp_p_d;
    logic [3:0]                   inflight_q, inflight_d;

    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] rsp_hs;
    logic             gnt_any;
    logic [ID_W-1:0]  gnt_id;
    logic             cap_v;
    logic [ID_W-1:0]  cap_id;
    int               idx;

    // First eligible requester at or after ptr wins, wrapping around.
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!gnt_any && req_valid[ID_W'(idx)]
                && !busy_q[ID_W'(idx)]) begin
                gnt_any             = 1'b1;
                gnt_id              = ID_W'(idx);
                grant[ID_W'(idx)]   = 1'b1;
            end
        end
    end

    assign rsp_hs = rsp_valid_q & rsp_ready;
    assign cap_v  = tag_vld_q[MUL_LAT-1];
    assign cap_id = tag_id_q[MUL_LAT-1];

    always_comb begin
        busy_d      = (busy_q & ~rsp_hs) | grant;
        ptr_d       = ptr_q;
        mul_valid_d = gnt_any;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        iss_id_d    = iss_id_q;
        if (gnt_any) begin
            ptr_d    = ID_W'((int'(gnt_id) + 1) % N_REQ);
            mul_a_d  = req_a[int'(gnt_id)*OP_W +: OP_W];
            mul_b_d  = req_b[int'(gnt_id)*OP_W +: OP_W];
            iss_id_d = gnt_id;
        end

        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = mul_valid_q;
        tag_id_d[0]  = iss_id_q;
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        rsp_valid_d = rsp_valid_q & ~rsp_hs;
        rsp_p_d     = rsp_p_q;
        if (cap_v) begin
            rsp_valid_d[cap_id] = 1'b1;
            rsp_p_d[cap_id]     = mul_p;
        end

        inflight_d = inflight_q;
        if (gnt_any && !cap_v) begin
            inflight_d = inflight_q + 4'd1;
        end else if (!gnt_any && cap_v) begin
            inflight_d = inflight_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            ptr_q       <= '0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            iss_id_q    <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= '0;
            inflight_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            iss_id_q    <= iss_id_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            inflight_q  <= inflight_d;
        end
    end

    assign req_ready    = grant;
    assign mul_valid    = mul_valid_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_p        = rsp_p_q;
    assign inflight_cnt = inflight_q;

endmodule

// File: tb/tb_mbe_mul_sched.sv
// Directed bench for mbe_mul_sched with a 2-cycle signed multiplier model.
// Cycle-exact vector table plus arbitration, backpressure and reset sequences.
module tb_mbe_mul_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [95:0]  req_a = '0;
    logic [95:0]  req_b = '0;
    logic         mul_valid;
    logic [23:0]  mul_a;
    logic [23:0]  mul_b;
    logic [47:0]  mul_p;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready = '1;
    logic [191:0] rsp_p;
    logic [3:0]   inflight_cnt;

    logic signed [47:0] sa, sb, prod;
    logic [47:0]        p1 = '0;
    logic [47:0]        p2 = '0;
    logic [47:0]        exp_rsp [4];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          id;
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] p;
    } vec_t;

    vec_t tbl [5];

    mbe_mul_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .mul_valid    (mul_valid),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_p        (mul_p),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_p        (rsp_p),
        .inflight_cnt (inflight_cnt)
    );

    always #5 clk = ~clk;

    // External multiplier: two stages, garbage when idle.
    assign sa    = $signed({{24{mul_a[23]}}, mul_a});
    assign sb    = $signed({{24{mul_b[23]}}, mul_b});
    assign prod  = sa * sb;
    assign mul_p = p2;

    always @(posedge clk) begin
        p1 <= mul_valid ? prod : 48'hBAD0BAD0BAD0;
        p2 <= p1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [191:0] act,
                       input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [191:0] model_rsp();
        logic [191:0] v;
        for (int i = 0; i < 4; i++) v[i*48 +: 48] = exp_rsp[i];
        return v;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) exp_rsp[i] = '0;
    endtask

    task automatic op1(input int id,
                       input logic [23:0] a,
                       input logic [23:0] b,
                       input logic [47:0] p);
        req_valid          = 4'(1 << id);
        req_a[id*24 +: 24] = a;
        req_b[id*24 +: 24] = b;
        #1;
        chk("op_grant", req_ready, 192'(1 << id));
        tick();
        req_valid = '0;
        chk("op_mvalid1", mul_valid, 1);
        chk("op_mul_a", mul_a, a);
        chk("op_mul_b", mul_b, b);
        chk("op_infl_t1", inflight_cnt, 1);
        tick();
        chk("op_mvalid0", mul_valid, 0);
        chk("op_infl_t2", inflight_cnt, 1);
        chk("op_rsp_t2", rsp_valid, 0);
        tick();
        chk("op_infl_t3", inflight_cnt, 1);
        chk("op_rsp_t3", rsp_valid, 0);
        tick();
        exp_rsp[id] = p;
        chk("op_rsp_t4", rsp_valid, 192'(1 << id));
        chk("op_rsp_p", rsp_p, model_rsp());
        chk("op_infl_t4", inflight_cnt, 0);
        tick();
        chk("op_rsp_t5", rsp_valid, 0);
    endtask

    initial begin
        logic [3:0] e_rdy [8];
        logic [3:0] e_inf [8];
        logic [3:0] e_rsp [8];
        logic [3:0] x;

        tbl[0] = '{0, 24'd3,      24'd5,      48'd15};
        tbl[1] = '{1, 24'h800000, 24'h800000, 48'h400000000000};
        tbl[2] = '{2, 24'hFFFFFF, 24'h000002, 48'hFFFFFFFFFFFE};
        tbl[3] = '{3, 24'h7FFFFF, 24'h7FFFFF, 48'h3FFFFF000001};
        tbl[4] = '{2, 24'h000000, 24'h123456, 48'h0};

        // Reset state
        do_reset();
        chk("rst_mvalid", mul_valid, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_rsp_v", rsp_valid, 0);
        chk("rst_rsp_p", rsp_p, 0);
        chk("rst_infl", inflight_cnt, 0);

        // Single-op vector table
        for (int i = 0; i < 5; i++) begin
            op1(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p);
        end

        // All four requesters from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*24 +: 24] = 24'(i + 1);
            req_b[i*24 +: 24] = 24'(10 * (i + 1));
        end
        e_rdy = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
        e_inf = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
        e_rsp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) req_valid = '0;
            chk("all_infl", inflight_cnt, e_inf[c]);
            chk("all_rsp_v", rsp_valid, e_rsp[c]);
            if (c >= 1 && c <= 4) chk("all_mul_a", mul_a, c);
            #1;
            chk("all_grant", req_ready, e_rdy[c]);
            tick();
        end
        chk("all_rsp_p", rsp_p,
            {48'd160, 48'd90, 48'd40, 48'd10});

        // Requester 1 held off by its own response backpressure
        do_reset();
        rsp_ready      = 4'b1101;
        req_a[23:0]    = 24'd2;
        req_b[23:0]    = 24'd2;
        req_a[47:24]   = 24'd7;
        req_b[47:24]   = 24'd6;
        req_valid      = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            if (c == 0 || c == 5 || c == 10) x = 4'h1;
            else if (c == 1) x = 4'h2;
            else x = 4'h0;
            #1;
            chk("bp_grant", req_ready, x);
            if (c >= 5) chk("bp_rsp1_hold", rsp_valid[1], 1);
            tick();
        end
        chk("bp_rsp1_p", rsp_p[95:48], 48'd42);
        req_valid    = 4'b0010;
        req_b[47:24] = 24'd9;
        rsp_ready    = 4'b1111;
        #1;
        chk("bp_no_same_cycle", req_ready, 0);
        tick();
        rsp_ready = 4'b1101;
        chk("bp_rsp1_clr", rsp_valid[1], 0);
        #1;
        chk("bp_regrant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        chk("bp_rsp1_v2", rsp_valid[1], 1);
        chk("bp_rsp1_p2", rsp_p[95:48], 48'd63);

        // Fairness: pointer at 2 after granting requester 1
        do_reset();
        req_valid = 4'b0010;
        #1;
        chk("fair_g1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("fair_g3", req_ready, 4'b1000);
        tick();
        #1;
        chk("fair_g0", req_ready, 4'b0001);
        tick();
        req_valid = '0;

        // Reset one cycle after an accept
        do_reset();
        req_valid   = 4'b0001;
        req_a[23:0] = 24'd3;
        req_b[23:0] = 24'd5;
        #1;
        chk("rr_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        rst_n     = 1'b0;
        chk("rr_mvalid", mul_valid, 1);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("rr_rsp_v", rsp_valid, 0);
            chk("rr_infl", inflight_cnt, 0);
            chk("rr_mvalid0", mul_valid, 0);
            tick();
        end
        chk("rr_rsp_p", rsp_p, 0);
        op1(2, 24'd4, 24'd4, 48'd16);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
